// File: rtl/param_seq_divider_if.sv
// Handshake and operand/result bundle between the sequencer and the sequential divider.
interface param_seq_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             go;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             zero_error;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output go, is_signed, dividend, divisor,
        input  busy, done, zero_error, quotient, remainder
    );

    modport slave (
        input  go, is_signed, dividend, divisor,
        output busy, done, zero_error, quotient, remainder
    );
endinterface

// File: rtl/param_seq_divider.sv
// Multi-cycle restoring divider with run-time signed mode, busy/done handshake,
// sticky divide-by-zero flag and defined overflow result.
module param_seq_divider #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    param_seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic             sq, sr, zdiv;
    logic             busy_q, done_q, zero_q;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             busy_n, done_n;

    logic             accept_c, sgn_c, a_neg_c, b_neg_c, div_zero_c;
    logic [WIDTH-1:0] a_abs_c, b_abs_c;
    logic [WIDTH:0]   r_sh_c;
    logic [WIDTH-1:0] q_sh_c;
    logic [WIDTH+1:0] t_c;

    // Operand conditioning; the most-negative value maps to 2^(WIDTH-1) on WIDTH bits
    assign sgn_c      = (SIGNED_EN != 0) && bus.is_signed;
    assign a_neg_c    = sgn_c && bus.dividend[WIDTH-1];
    assign b_neg_c    = sgn_c && bus.divisor[WIDTH-1];
    assign a_abs_c    = a_neg_c ? -bus.dividend : bus.dividend;
    assign b_abs_c    = b_neg_c ? -bus.divisor  : bus.divisor;
    assign div_zero_c = (bus.divisor == '0);
    // busy_q also covers the done cycle, so go cannot slip in while done is high
    assign accept_c   = (state == IDLE) && bus.go && !busy_q;

    // One restoring step: shift {R,Q} left, trial-subtract D
    assign r_sh_c = {r[WIDTH-1:0], q[WIDTH-1]};
    assign q_sh_c = {q[WIDTH-2:0], 1'b0};
    assign t_c    = {1'b0, r_sh_c} - {2'b00, d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept_c) state_n = div_zero_c ? DONE : ITER;
            ITER: if (cnt == CW'(1)) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE) || (state == DONE);
        done_n = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            r      <= '0;
            q      <= '0;
            d      <= '0;
            sq     <= 1'b0;
            sr     <= 1'b0;
            zdiv   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            zero_q <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_n;
            done_q <= done_n;
            unique case (state)
                IDLE: if (accept_c) begin
                    sq     <= a_neg_c ^ b_neg_c;
                    sr     <= a_neg_c;
                    q      <= a_abs_c;
                    d      <= b_abs_c;
                    r      <= '0;
                    cnt    <= CW'(WIDTH);
                    zdiv   <= div_zero_c;
                    zero_q <= 1'b0;
                    // Divide-by-zero results are registered on the edge entering DONE
                    if (div_zero_c) begin
                        quo_q <= '1;
                        rem_q <= bus.dividend;
                    end
                end
                ITER: begin
                    r   <= t_c[WIDTH+1] ? r_sh_c : t_c[WIDTH:0];
                    q   <= {q_sh_c[WIDTH-1:1], ~t_c[WIDTH+1]};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    quo_q <= sq ? -q : q;
                    rem_q <= sr ? -r[WIDTH-1:0] : r[WIDTH-1:0];
                end
                DONE: if (zdiv) zero_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.zero_error = zero_q;
    assign bus.quotient   = quo_q;
    assign bus.remainder  = rem_q;
endmodule

// File: tb/tb_param_seq_divider.sv
// Self-checking bench: directed cases plus random operands against an arithmetic
// reference model, on an 8-bit signed-capable and a 16-bit unsigned-only divider.
module tb_param_seq_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    param_seq_divider_if #(.WIDTH(8))  bus8 ();
    param_seq_divider_if #(.WIDTH(16)) bus16 ();

    param_seq_divider #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
    );
    param_seq_divider #(.WIDTH(16), .SIGNED_EN(0)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer division truncates toward zero, % takes the dividend's sign
    function automatic void model8(input logic s, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] qo, output logic [7:0] ro, output logic z);
        int ia, ib;
        z = (b == 8'd0);
        if (z) begin
            qo = 8'hFF; ro = a;
        end else if (s) begin
            ia = $signed(a);
            ib = $signed(b);
            if (ia == -128 && ib == -1) begin
                qo = 8'h80; ro = 8'h00;
            end else begin
                qo = 8'(ia / ib); ro = 8'(ia % ib);
            end
        end else begin
            qo = a / b; ro = a % b;
        end
    endfunction

    task automatic run_op8(input logic s, input logic [7:0] a, input logic [7:0] b, input bit intf);
        logic [7:0] eq, er;
        logic       ez;
        int         lat, bcnt;
        bit         seen;
        model8(s, a, b, eq, er, ez);
        @(negedge clk);
        bus8.go = 1'b1; bus8.is_signed = s; bus8.dividend = a; bus8.divisor = b;
        @(posedge clk); #1;
        bus8.go = 1'b0; bus8.is_signed = 1'($urandom);
        bus8.dividend = 8'($urandom); bus8.divisor = 8'($urandom);
        check("zerr_clear8", 32'(bus8.zero_error), 32'd0);
        bcnt = int'(bus8.busy); lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus8.busy) bcnt++;
            if (bus8.done) seen = 1'b1;
            bus8.go = intf && (lat == 2 || lat == 5);
        end
        bus8.go = 1'b0;
        check("latency8", 32'(lat), ez ? 32'd1 : 32'd10);
        check("busy_cycles8", 32'(bcnt), ez ? 32'd2 : 32'd11);
        check("quotient8", 32'(bus8.quotient), 32'(eq));
        check("remainder8", 32'(bus8.remainder), 32'(er));
        check("zero_error8", 32'(bus8.zero_error), 32'(ez));
        @(posedge clk); #1;
        check("done_pulse8", 32'(bus8.done), 32'd0);
        check("idle8", 32'(bus8.busy), 32'd0);
    endtask

    task automatic run_op16(input logic s, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er;
        logic        ez;
        int          lat;
        bit          seen;
        ez = (b == 16'd0);
        eq = ez ? 16'hFFFF : a / b;
        er = ez ? a : a % b;
        @(negedge clk);
        bus16.go = 1'b1; bus16.is_signed = s; bus16.dividend = a; bus16.divisor = b;
        @(posedge clk); #1;
        bus16.go = 1'b0; bus16.dividend = 16'($urandom); bus16.divisor = 16'($urandom);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (bus16.done) seen = 1'b1;
        end
        check("latency16", 32'(lat), ez ? 32'd1 : 32'd18);
        check("quotient16", 32'(bus16.quotient), 32'(eq));
        check("remainder16", 32'(bus16.remainder), 32'(er));
        check("zero_error16", 32'(bus16.zero_error), 32'(ez));
        @(posedge clk); #1;
        check("idle16", 32'(bus16.busy), 32'd0);
    endtask

    initial begin
        bit         seen;
        logic [7:0] ra, rb;
        logic       rs;
        rst_n = 1'b0;
        bus8.go = 1'b0; bus8.is_signed = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
        bus16.go = 1'b0; bus16.is_signed = 1'b0; bus16.dividend = '0; bus16.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_zerr", 32'(bus8.zero_error), 32'd0);
        check("rst_quo", 32'(bus8.quotient), 32'd0);
        check("rst_rem", 32'(bus8.remainder), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases; first go lands on the first edge after reset release
        run_op8(1'b0, 8'd200, 8'd7, 1'b0);
        run_op8(1'b1, 8'hF9, 8'h02, 1'b0);
        run_op8(1'b1, 8'h07, 8'hFE, 1'b0);
        run_op8(1'b1, 8'h80, 8'hFF, 1'b0);
        run_op8(1'b0, 8'h55, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("zerr_sticky", 32'(bus8.zero_error), 32'd1);
        run_op8(1'b0, 8'd100, 8'd9, 1'b1);

        // Abort mid-iteration with reset
        @(negedge clk);
        bus8.go = 1'b1; bus8.is_signed = 1'b0; bus8.dividend = 8'd100; bus8.divisor = 8'd3;
        @(posedge clk); #1;
        bus8.go = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus8.busy), 32'd0);
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_quo", 32'(bus8.quotient), 32'd0);
        check("abort_rem", 32'(bus8.remainder), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        run_op8(1'b0, 8'd9, 8'd3, 1'b0);

        // Random 8-bit operands with corner values mixed in
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: ra = 8'h80;
                2: rb = 8'hFF;
                3: begin ra = 8'h80; rb = 8'hFF; end
                default: ;
            endcase
            run_op8(rs, ra, rb, 1'b0);
        end

        // 16-bit instance ignores is_signed
        run_op16(1'b1, 16'd65535, 16'd255);
        run_op16(1'b1, 16'h8000, 16'hFFFF);
        for (int i = 0; i < 15; i++)
            run_op16(1'($urandom), 16'($urandom), (i == 7) ? 16'd0 : 16'($urandom_range(1, 65535)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
